snake_segment_buffer: RTL and testbench

//  Parametrised store of snake body segment coordinates. Index 0 is the head.
//  On each accepted move it shifts every segment one slot towards the tail and loads a new head.
//  It supports growth up to MAX_LEN. A zero-latency random read port serves the draw FSM.
//  It replaces the fixed 4-segment shift register that sits between the head up/down counters
//  and the VGA draw/erase FSM.

---
 rtl/snake_segment_buffer.sv | 191 +++++++++++++++++++
 tb/tb_snake_segment_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_segment_buffer.sv
// rtl/snake_segment_buffer.sv - snake body segment store with shift-on-move, growth and self-collision scan
//
// Purpose:
//   Holds the snake body coordinates, index 0 being the head. Each accepted move shifts every
//   segment one slot towards the tail and loads a new head; grow lengthens the body up to MAX_LEN.
//   A combinational read port serves the draw FSM.
//   Optional feature macro: SNAKE_SELF_COLLIDE_EN (adds the IDLE/SCAN self-collision FSM).
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_init         synchronous re-initialise to the reset layout
//   i_move_valid   move request
//   o_move_ready   move can be accepted this cycle
//   i_head_x/y     new head coordinate, sampled on an accepted move
//   i_grow         lengthen by one with an accepted move
//   i_rd_idx       segment index to read
//   o_rd_x/y       coordinate of segment i_rd_idx (0 when o_rd_valid = 0)
//   o_rd_valid     i_rd_idx < o_length
//   o_length       current segment count
//   o_full         o_length == MAX_LEN
//   o_collide      sticky self-collision flag
//   o_busy         collision scan in progress
`timescale 1ns/1ps

module snake_segment_buffer #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int X0       = 39,
  parameter int Y0       = 59,
  parameter int STEP     = 10,
  localparam int IW      = $clog2(MAX_LEN)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_init,
  input  logic          i_move_valid,
  output logic          o_move_ready,
  input  logic [XW-1:0] i_head_x,
  input  logic [YW-1:0] i_head_y,
  input  logic          i_grow,
  input  logic [IW-1:0] i_rd_idx,
  output logic [XW-1:0] o_rd_x,
  output logic [YW-1:0] o_rd_y,
  output logic          o_rd_valid,
  output logic [IW:0]   o_length,
  output logic          o_full,
  output logic          o_collide,
  output logic          o_busy
);

  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];
  logic [IW:0]   r_length;

  logic [XW-1:0] w_lay_x [MAX_LEN];
  logic [YW-1:0] w_lay_y [MAX_LEN];
  logic          w_accept;
  logic          w_full;
  logic          w_rd_valid;
  logic          w_move_ready;

  // Reset/init layout: a horizontal line trailing left of the head, unused slots zeroed.
  // X wraps modulo 2^XW when X0 - i*STEP goes negative.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      w_lay_x[i] = '0;
      w_lay_y[i] = '0;
      if (i < INIT_LEN) begin
        w_lay_x[i] = XW'(X0 - i * STEP);
        w_lay_y[i] = YW'(Y0);
      end
    end
  end

  assign w_full   = (r_length == (IW+1)'(MAX_LEN));
  // init wins over a move in the same cycle; the move is dropped.
  assign w_accept = i_move_valid & w_move_ready & ~i_init;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= w_lay_x[i];
        r_seg_y[i] <= w_lay_y[i];
      end
      r_length <= (IW+1)'(INIT_LEN);
    end else if (i_init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= w_lay_x[i];
        r_seg_y[i] <= w_lay_y[i];
      end
      r_length <= (IW+1)'(INIT_LEN);
    end else if (w_accept) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= i_head_x;
      r_seg_y[0] <= i_head_y;
      // When full the tail segment simply falls off the end of the shift.
      if (i_grow && !w_full) begin
        r_length <= r_length + (IW+1)'(1);
      end
    end
  end

  // Zero-latency read; stale storage beyond the current length is masked to zero.
  assign w_rd_valid = ({1'b0, i_rd_idx} < r_length);
  assign o_rd_valid = w_rd_valid;
  assign o_rd_x     = w_rd_valid ? r_seg_x[i_rd_idx] : '0;
  assign o_rd_y     = w_rd_valid ? r_seg_y[i_rd_idx] : '0;
  assign o_length   = r_length;
  assign o_full     = w_full;

`ifdef SNAKE_SELF_COLLIDE_EN
  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_scan_idx;
  logic [IW-1:0] w_scan_idx_nxt;
  logic          r_collide;
  logic          w_collide_nxt;
  logic          w_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_scan_idx <= '0;
      r_collide  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_scan_idx <= w_scan_idx_nxt;
      r_collide  <= w_collide_nxt;
    end
  end

  // The scan runs on the post-move body, which cannot change while SCAN blocks moves.
  always_comb begin
    w_state_nxt    = r_state;
    w_scan_idx_nxt = r_scan_idx;
    w_collide_nxt  = r_collide;
    w_move_ready   = 1'b1;
    w_busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_move_valid) begin
          w_state_nxt    = S_SCAN;
          w_scan_idx_nxt = IW'(1);
        end
      end
      S_SCAN: begin
        w_move_ready = 1'b0;
        w_busy       = 1'b1;
        // With length 1 the index is already past the body: one idle cycle, no compare.
        if (({1'b0, r_scan_idx} < r_length) &&
            (r_seg_x[r_scan_idx] == r_seg_x[0]) &&
            (r_seg_y[r_scan_idx] == r_seg_y[0])) begin
          w_collide_nxt = 1'b1;
        end
        if ({1'b0, r_scan_idx} >= (r_length - (IW+1)'(1))) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_scan_idx_nxt = r_scan_idx + IW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // init aborts any scan and clears the sticky flag.
    if (i_init) begin
      w_state_nxt    = S_IDLE;
      w_scan_idx_nxt = '0;
      w_collide_nxt  = 1'b0;
    end
  end

  assign o_move_ready = w_move_ready;
  assign o_busy       = w_busy;
  assign o_collide    = r_collide;
`else
  assign w_move_ready = 1'b1;
  assign o_move_ready = w_move_ready;
  assign o_busy       = 1'b0;
  assign o_collide    = 1'b0;
`endif

endmodule

// File: tb/tb_snake_segment_buffer.sv
// tb/tb_snake_segment_buffer.sv - self-checking bench for snake_segment_buffer
`timescale 1ns/1ps

module tb_snake_segment_buffer;
  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic       mv = 1'b0;
  logic       grow = 1'b0;
  logic [7:0] hx = '0;
  logic [6:0] hy = '0;
  logic [3:0] rd_idx = '0;
  logic       move_ready;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_valid;
  logic [4:0] length;
  logic       full;
  logic       collide;
  logic       busy;

  snake_segment_buffer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_init       (init),
    .i_move_valid (mv),
    .o_move_ready (move_ready),
    .i_head_x     (hx),
    .i_head_y     (hy),
    .i_grow       (grow),
    .i_rd_idx     (rd_idx),
    .o_rd_x       (rd_x),
    .o_rd_y       (rd_y),
    .o_rd_valid   (rd_valid),
    .o_length     (length),
    .o_full       (full),
    .o_collide    (collide),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: body as a fixed-capacity queue, head at the front.
  int mx[$];
  int my[$];
  int mlen;
  bit mcol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_col();
`ifdef SNAKE_SELF_COLLIDE_EN
    return int'(mcol);
`else
    return 0;
`endif
  endfunction

  task automatic model_init();
    mx.delete();
    my.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < 4) begin
        mx.push_back((39 - 10 * i) & 255);
        my.push_back(59);
      end else begin
        mx.push_back(0);
        my.push_back(0);
      end
    end
    mlen = 4;
    mcol = 1'b0;
  endtask

  task automatic model_move(input int x, input int y, input bit g);
    mx.push_front(x);
    my.push_front(y);
    mx.delete(MAX_LEN);
    my.delete(MAX_LEN);
    if (g && mlen < MAX_LEN) mlen++;
    for (int k = 1; k < mlen; k++) begin
      if (mx[k] == mx[0] && my[k] == my[0]) mcol = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " length"}, length, mlen);
    chk({tag, " full"}, full, (mlen == MAX_LEN));
    chk({tag, " collide"}, collide, exp_col());
    chk({tag, " busy"}, busy, 0);
    chk({tag, " ready"}, move_ready, 1);
    for (int i = 0; i < MAX_LEN; i++) begin
      @(negedge clk);
      rd_idx = 4'(i);
      #2;
      chk($sformatf("%s rd_valid[%0d]", tag, i), rd_valid, (i < mlen));
      chk($sformatf("%s rd_x[%0d]", tag, i), rd_x, (i < mlen) ? mx[i] : 0);
      chk($sformatf("%s rd_y[%0d]", tag, i), rd_y, (i < mlen) ? my[i] : 0);
    end
  endtask

  task automatic do_move(input int x, input int y, input bit g);
    int n;
    int cyc;
    n = 0;
    while (move_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", move_ready, 1);
    hx = 8'(x);
    hy = 7'(y);
    grow = g;
    mv = 1'b1;
    @(posedge clk);
    #1;
    mv = 1'b0;
    grow = 1'b0;
    model_move(x, y, g);
`ifdef SNAKE_SELF_COLLIDE_EN
    cyc = (mlen > 1) ? mlen - 1 : 1;
    for (int c = 0; c < cyc; c++) begin
      chk($sformatf("scan_busy c%0d", c), busy, 1);
      chk($sformatf("scan_ready c%0d", c), move_ready, 0);
      @(posedge clk);
      #1;
    end
`else
    cyc = 0;
`endif
    chk("post_busy", busy, 0);
    chk("post_ready", move_ready, 1);
  endtask

  initial begin
    int ex1[5];
    ex1 = '{39, 29, 19, 9, 0};

    // Asynchronous reset: outputs settle before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_length", length, 4);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_collide", collide, 0);
    chk("rst_ready", move_ready, 1);
    #20;
    @(negedge clk);
    rst = 1'b0;
    model_init();

    // Reset layout against literal coordinates.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd_idx = 4'(i);
      #2;
      chk($sformatf("t1 x%0d", i), rd_x, ex1[i]);
      chk($sformatf("t1 y%0d", i), rd_y, (i < 4) ? 59 : 0);
      chk($sformatf("t1 v%0d", i), rd_valid, (i < 4));
    end
    check_all("t1");

    // Plain move without growth.
    @(posedge clk);
    #1;
    do_move(49, 59, 1'b0);
    @(negedge clk);
    rd_idx = 4'd0;
    #2;
    chk("t2 head_x", rd_x, 49);
    rd_idx = 4'd3;
    #1;
    chk("t2 tail_x", rd_x, 19);
    check_all("t2");

    // Grow to capacity, then two more grow moves with the length pinned.
    @(posedge clk);
    #1;
    for (int k = 0; k < 12; k++) do_move(59 + 10 * k, 59, 1'b1);
    chk("t3 len16", length, 16);
    chk("t3 full", full, 1);
    do_move(200, 10, 1'b1);
    do_move(201, 10, 1'b1);
    chk("t3 len_hold", length, 16);
    check_all("t3");

    // Self-collision: head onto the old seg[2] coordinate of the reset layout.
    @(posedge clk);
    #1;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    model_init();
    do_move(19, 59, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4 collide_hold", collide, exp_col());
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    model_init();
    chk("t4 collide_clr", collide, 0);

    // init and move together: the move is discarded.
    hx = 8'd77;
    hy = 7'd33;
    grow = 1'b1;
    mv = 1'b1;
    init = 1'b1;
    @(posedge clk);
    #1;
    mv = 1'b0;
    init = 1'b0;
    grow = 1'b0;
    model_init();
    check_all("t5");

    // Randomised moves on a coarse grid so self-collisions occur.
    @(posedge clk);
    #1;
    for (int r = 0; r < 40; r++) begin
      do_move(int'($urandom_range(0, 4)) * 10 + 9, int'($urandom_range(57, 59)),
              1'($urandom_range(0, 1)));
      if (r % 8 == 7) check_all($sformatf("rnd%0d", r));
      @(posedge clk);
      #1;
    end
    check_all("rnd_end");

    // init right after an accepted move aborts any scan.
    @(posedge clk);
    #1;
    hx = 8'd5;
    hy = 7'd5;
    mv = 1'b1;
    @(posedge clk);
    #1;
    mv = 1'b0;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    model_init();
    chk("t6 abort_busy", busy, 0);
    check_all("t6");

    // Grow a little, start a move, then assert Reset between clock edges.
    @(posedge clk);
    #1;
    do_move(100, 100, 1'b1);
    do_move(19, 59, 1'b1);
    hx = 8'd60;
    hy = 7'd60;
    mv = 1'b1;
    @(posedge clk);
    #1;
    mv = 1'b0;
    #2;
    rd_idx = 4'd0;
    rst = 1'b1;
    #1;
    chk("t7 length", length, 4);
    chk("t7 busy", busy, 0);
    chk("t7 collide", collide, 0);
    chk("t7 ready", move_ready, 1);
    chk("t7 full", full, 0);
    chk("t7 rd_x", rd_x, 39);
    chk("t7 rd_y", rd_y, 59);
    @(negedge clk);
    rst = 1'b0;
    model_init();
    check_all("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
